// File: rtl/crc_parallel_gen.sv
// Byte-parallel CRC engine with configurable width/polynomial/reflection that
// absorbs one byte per clock and streams the finished CRC out MSB-byte first.
module crc_parallel_gen #(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter logic [CRC_W-1:0] INIT   = 16'hFFFF,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [7:0]       crc_in,
    input  logic             in_valid,
    input  logic             d_finish,
    output logic [7:0]       crc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CRC_W-1:0] crc_full
);

    localparam int NB    = CRC_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_crc_full;
    logic [7:0]       r_crc_out;
    logic             r_out_valid;
    logic             r_out_last;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CRC_W-1:0] w_crc_step;
    logic [CRC_W-1:0] w_crc_next;
    logic [CRC_W-1:0] w_final;
    logic             w_xfer;
    logic             w_xfer_last;

    // One full byte through the bit-serial recurrence, unrolled into logic.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                   input logic [7:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int b = 0; b < 8; b++) begin
            fb = r[CRC_W-1] ^ (REFIN ? d[b] : d[7-b]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] bit_reverse(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        for (int j = 0; j < CRC_W; j++) begin
            r[j] = c[CRC_W-1-j];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] crc_finalize(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        r = REFOUT ? bit_reverse(c) : c;
        return r ^ XOROUT;
    endfunction

    // Byte i of the result, counting from the most-significant byte.
    function automatic logic [7:0] sel_byte(input logic [CRC_W-1:0] v,
                                            input logic [IDX_W-1:0] i);
        logic [CRC_W-1:0] s;
        s = v >> (8 * (NB - 1 - int'(i)));
        return s[7:0];
    endfunction

    always_comb begin
        w_crc_step  = crc_step(r_crc, crc_in);
        w_crc_next  = in_valid ? w_crc_step : r_crc;
        w_final     = crc_finalize(w_crc_next);
        w_idx_nxt   = r_idx + IDX_W'(1);
        w_xfer      = r_out_valid & out_ready;
        w_xfer_last = w_xfer & (r_idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (load)          w_state_nxt = S_CALC;
                else if (d_finish) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (load)             w_state_nxt = S_CALC;
                else if (w_xfer_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Datapath: CRC accumulator, captured result and the byte-serial output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc       <= INIT;
            r_crc_full  <= '0;
            r_crc_out   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load) r_crc <= INIT;
                end
                S_CALC: begin
                    if (load) begin
                        r_crc <= INIT;
                    end else begin
                        r_crc <= w_crc_next;
                        if (d_finish) begin
                            r_crc_full  <= w_final;
                            r_crc_out   <= w_final[CRC_W-1 -: 8];
                            r_out_valid <= 1'b1;
                            r_out_last  <= (NB == 1);
                            r_idx       <= '0;
                        end
                    end
                end
                S_OUT: begin
                    if (load) begin
                        r_crc       <= INIT;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_xfer_last) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else if (w_xfer) begin
                        r_idx      <= w_idx_nxt;
                        r_crc_out  <= sel_byte(r_crc_full, w_idx_nxt);
                        r_out_last <= (w_idx_nxt == LAST_IDX);
                    end
                end
                default: r_crc <= INIT;
            endcase
        end
    end

    assign crc_out   = r_crc_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign crc_full  = r_crc_full;

endmodule

// File: tb/tb_crc_parallel_gen.sv
// Bench for crc_parallel_gen: four configurations share one stimulus stream and
// are checked every cycle against a frame-level CRC model.
`timescale 1ns/1ps
module tb_crc_parallel_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic       in_valid;
    logic       d_finish;
    logic       out_ready;
    logic [7:0] crc_in;

    always #5 clk = ~clk;

    logic [7:0]  ob [4];
    logic        ov [4];
    logic        ol [4];
    logic        bz [4];
    logic [31:0] of [4];
    logic [15:0] f_a;
    logic [15:0] f_b;
    logic [7:0]  f_c;
    logic [31:0] f_d;

    assign of[0] = {16'h0, f_a};
    assign of[1] = {16'h0, f_b};
    assign of[2] = {24'h0, f_c};
    assign of[3] = f_d;

    // k=0 CRC-16/CCITT-FALSE, k=1 XMODEM, k=2 CRC-8, k=3 CRC-32
    localparam int          PW  [4] = '{16, 16, 8, 32};
    localparam logic [31:0] PP  [4] = '{32'h1021, 32'h1021, 32'h07, 32'h04C11DB7};
    localparam logic [31:0] PI  [4] = '{32'hFFFF, 32'h0, 32'h0, 32'hFFFFFFFF};
    localparam bit          PRI [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit          PRO [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] PX  [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFFFFFF};

    crc_parallel_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .REFIN(1'b0),
                       .REFOUT(1'b0), .XOROUT(16'h0000)) u_a (
        .clk(clk), .rst(rst), .load(load), .crc_in(crc_in), .in_valid(in_valid),
        .d_finish(d_finish), .crc_out(ob[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_last(ol[0]), .busy(bz[0]), .crc_full(f_a));

    crc_parallel_gen #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .REFIN(1'b0),
                       .REFOUT(1'b0), .XOROUT(16'h0000)) u_b (
        .clk(clk), .rst(rst), .load(load), .crc_in(crc_in), .in_valid(in_valid),
        .d_finish(d_finish), .crc_out(ob[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_last(ol[1]), .busy(bz[1]), .crc_full(f_b));

    crc_parallel_gen #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .REFIN(1'b0),
                       .REFOUT(1'b0), .XOROUT(8'h00)) u_c (
        .clk(clk), .rst(rst), .load(load), .crc_in(crc_in), .in_valid(in_valid),
        .d_finish(d_finish), .crc_out(ob[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_last(ol[2]), .busy(bz[2]), .crc_full(f_c));

    crc_parallel_gen #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .REFIN(1'b1),
                       .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF)) u_d (
        .clk(clk), .rst(rst), .load(load), .crc_in(crc_in), .in_valid(in_valid),
        .d_finish(d_finish), .crc_out(ob[3]), .out_valid(ov[3]), .out_ready(out_ready),
        .out_last(ol[3]), .busy(bz[3]), .crc_full(f_d));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Whole-frame CRC straight from the bitwise definition.
    function automatic logic [31:0] crc_model(input int k, input logic [7:0] d [64], input int n);
        int          w;
        logic [31:0] mask;
        logic [31:0] c;
        logic [31:0] r;
        logic        db;
        logic        fb;
        w    = PW[k];
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
        c    = PI[k] & mask;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                db = PRI[k] ? d[i][b] : d[i][7-b];
                fb = c[w-1] ^ db;
                c  = ((c << 1) ^ (fb ? PP[k] : 32'h0)) & mask;
            end
        end
        r = c;
        if (PRO[k]) begin
            r = 32'h0;
            for (int j = 0; j < w; j++) r[j] = c[w-1-j];
        end
        return (r ^ PX[k]) & mask;
    endfunction

    // Frame-level model: phase 0 idle, 1 collecting bytes, 2 sending bytes.
    int          m_ph   [4];
    int          m_idx  [4];
    int          m_n    [4];
    logic [31:0] m_full [4];
    logic [7:0]  m_buf  [4][64];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_ph[k] = 0; m_idx[k] = 0; m_n[k] = 0; m_full[k] = 32'h0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (m_ph[k])
                    0: if (load) begin m_ph[k] = 1; m_n[k] = 0; end
                    1: begin
                        if (load) m_n[k] = 0;
                        else begin
                            if (in_valid && m_n[k] < 64) begin
                                m_buf[k][m_n[k]] = crc_in;
                                m_n[k]++;
                            end
                            if (d_finish) begin
                                m_full[k] = crc_model(k, m_buf[k], m_n[k]);
                                m_ph[k]   = 2;
                                m_idx[k]  = 0;
                            end
                        end
                    end
                    default: begin
                        if (load) begin m_ph[k] = 1; m_n[k] = 0; end
                        else if (out_ready) begin
                            if (m_idx[k] == PW[k] / 8 - 1) m_ph[k] = 0;
                            else m_idx[k]++;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                int nb;
                nb = PW[k] / 8;
                chk($sformatf("k%0d busy", k), {31'h0, bz[k]}, {31'h0, m_ph[k] != 0});
                chk($sformatf("k%0d out_valid", k), {31'h0, ov[k]}, {31'h0, m_ph[k] == 2});
                chk($sformatf("k%0d crc_full", k), of[k], m_full[k]);
                if (m_ph[k] == 2) begin
                    chk($sformatf("k%0d crc_out", k), {24'h0, ob[k]},
                        {24'h0, 8'(m_full[k] >> (8 * (nb - 1 - m_idx[k])))});
                    chk($sformatf("k%0d out_last", k), {31'h0, ol[k]},
                        {31'h0, m_idx[k] == nb - 1});
                end
            end
        end
    end

    logic [7:0] lg [4][16];
    int         lc [4];

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int k = 0; k < 4; k++) begin
                if (ov[k] && out_ready && lc[k] < 16) begin
                    lg[k][lc[k]] = ob[k];
                    lc[k]++;
                end
            end
        end
    end

    logic [7:0] fr [64];
    logic [7:0] sd [64];
    int         rdy_mode = 0;

    task automatic set_std();
        for (int i = 0; i < 9; i++) fr[i] = 8'(49 + i);
    endtask

    task automatic clear_log();
        for (int k = 0; k < 4; k++) lc[k] = 0;
    endtask

    task automatic chk_log(input int k, input int cnt, input logic [31:0] val);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < lc[k] && i < 4; i++) v = (v << 8) | {24'h0, lg[k][i]};
        chk($sformatf("k%0d byte count", k), lc[k], cnt);
        chk($sformatf("k%0d byte stream", k), v, val);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s k%0d crc_out", tag, k), {24'h0, ob[k]}, 32'h0);
            chk($sformatf("%s k%0d out_valid", tag, k), {31'h0, ov[k]}, 32'h0);
            chk($sformatf("%s k%0d out_last", tag, k), {31'h0, ol[k]}, 32'h0);
            chk($sformatf("%s k%0d busy", tag, k), {31'h0, bz[k]}, 32'h0);
            chk($sformatf("%s k%0d crc_full", tag, k), of[k], 32'h0);
        end
    endtask

    task automatic set_ready(input int c);
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic send_frame(input int n, input int gap, input bit fin_sep);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            crc_in   = fr[i];
            d_finish = (i == n - 1) && !fin_sep;
            @(negedge clk);
            in_valid = 1'b0;
            d_finish = 1'b0;
            repeat (gap) @(negedge clk);
        end
        if (fin_sep) begin
            d_finish = 1'b1;
            @(negedge clk);
            d_finish = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while ((bz[0] || bz[1] || bz[2] || bz[3]) && c < budget) begin
            set_ready(c);
            @(negedge clk);
            c++;
        end
        chk("idle within budget", {31'h0, c >= budget}, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; load = 1'b0; in_valid = 1'b0; d_finish = 1'b0;
        crc_in = 8'h0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) lc[k] = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) sd[i] = 8'(49 + i);
        chk("model crc16 ffff", crc_model(0, sd, 9), 32'h29B1);
        chk("model crc16 0000", crc_model(1, sd, 9), 32'h31C3);
        chk("model crc8", crc_model(2, sd, 9), 32'hF4);
        chk("model crc32", crc_model(3, sd, 9), 32'hCBF43926);

        // Reference string, continuous input, out_ready high
        set_std(); clear_log(); rdy_mode = 0;
        send_frame(9, 0, 1'b0);
        wait_idle(50);
        chk_log(0, 2, 32'h29B1);
        chk_log(1, 2, 32'h31C3);
        chk_log(2, 1, 32'hF4);
        chk_log(3, 4, 32'hCBF43926);

        // Stalling out_ready 1-0-0 pattern
        clear_log(); rdy_mode = 1;
        send_frame(9, 0, 1'b0);
        wait_idle(100);
        chk_log(3, 4, 32'hCBF43926);
        chk_log(0, 2, 32'h29B1);

        // Gapped input
        clear_log(); rdy_mode = 0;
        send_frame(9, 1, 1'b0);
        wait_idle(50);
        chk_log(0, 2, 32'h29B1);

        // Restart mid-frame: earlier bytes must be dropped
        load = 1'b1; @(negedge clk); load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; crc_in = fr[i]; @(negedge clk);
        end
        in_valid = 1'b0;
        clear_log();
        send_frame(9, 0, 1'b0);
        wait_idle(50);
        chk_log(0, 2, 32'h29B1);

        // Abort during output after the first byte
        out_ready = 1'b1;
        send_frame(9, 0, 1'b0);
        @(negedge clk);
        load = 1'b1; @(negedge clk); load = 1'b0;
        chk("abort out_valid", {31'h0, ov[0]}, 32'h0);
        chk("abort crc_full held", of[0], 32'h29B1);
        fr[0] = 8'h41; fr[1] = 8'h42; fr[2] = 8'h43; fr[3] = 8'h44;
        send_frame(4, 0, 1'b0);
        wait_idle(50);
        set_std(); clear_log();
        send_frame(9, 0, 1'b0);
        wait_idle(50);
        chk_log(0, 2, 32'h29B1);

        // Asynchronous reset in the middle of a frame
        load = 1'b1; @(negedge clk); load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; crc_in = fr[i]; @(negedge clk);
        end
        #2 rst = 1'b0;
        #1 chk_zero("mid-frame reset");
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_log();
        send_frame(9, 0, 1'b0);
        wait_idle(50);
        chk_log(0, 2, 32'h29B1);

        // Randomized frames, backpressure, restarts and aborts
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) fr[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                load = 1'b1; @(negedge clk); load = 1'b0;
                in_valid = 1'b1; crc_in = 8'($urandom_range(0, 255)); @(negedge clk);
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            send_frame(n, int'($urandom_range(0, 2)), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 5) == 0) begin
                int r;
                r = int'($urandom_range(0, 3));
                for (int c = 0; c < r; c++) begin
                    set_ready(c);
                    @(negedge clk);
                end
                load = 1'b1; @(negedge clk); load = 1'b0;
            end else begin
                wait_idle(200);
            end
        end
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
